// File: rtl/mem_port_arbiter.sv
// Two-port main-memory arbiter: latches cache refill requests and grants whole line bursts round-robin.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADR_WIDTH      = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_cc02arb,
  input  logic [ADR_WIDTH-1:0]  adr_cc02arb,
  output logic                  ack_arb2cc0,
  input  logic                  req_cc12arb,
  input  logic [ADR_WIDTH-1:0]  adr_cc12arb,
  output logic                  ack_arb2cc1,
  output logic [WORD_WIDTH-1:0] dat_arb2cc,
  output logic                  req_arb2mem,
  output logic [ADR_WIDTH-1:0]  adr_arb2mem,
  input  logic                  ack_mem2arb,
  input  logic [WORD_WIDTH-1:0] dat_mem2arb,
  output logic [1:0]            gnt_arb,
  output logic                  err_arb
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BURST} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_pend0;
  logic                   r_pend1;
  logic                   r_rr_ptr;
  logic                   r_owner;
  logic [ADR_WIDTH-1:0]   r_adr_lat0;
  logic [ADR_WIDTH-1:0]   r_adr_lat1;
  logic [BEAT_W-1:0]      r_beat;
  logic                   w_active;
  logic                   w_beat_ack;
  logic                   w_last;
  logic                   w_end;
  logic                   w_tmo_hit;
  logic                   w_sel_owner;

  assign w_active    = (r_state != S_IDLE);
  assign w_beat_ack  = w_active & ack_mem2arb;
  assign w_last      = w_beat_ack && (r_beat == BEAT_W'(BURST_LEN - 1));
  assign w_end       = w_last | w_tmo_hit;
  // With both ports pending the round-robin pointer decides; otherwise the lone requester wins.
  assign w_sel_owner = (r_pend0 & r_pend1) ? r_rr_ptr : r_pend1;
  assign dat_arb2cc  = dat_mem2arb;

`ifdef ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;
  logic             r_err;

  assign w_tmo_hit = w_active && !ack_mem2arb && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  assign err_arb   = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_tmo_hit;
      if (!w_active || ack_mem2arb || w_tmo_hit) r_tmo <= '0;
      else                                       r_tmo <= r_tmo + 1'b1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign err_arb   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_arb2mem = 1'b0;
    adr_arb2mem = '0;
    gnt_arb     = 2'b00;
    ack_arb2cc0 = 1'b0;
    ack_arb2cc1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend0 | r_pend1) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        req_arb2mem = 1'b1;
        adr_arb2mem = r_owner ? r_adr_lat1 : r_adr_lat0;
        gnt_arb     = r_owner ? 2'b10 : 2'b01;
        ack_arb2cc0 = ack_mem2arb & ~r_owner;
        ack_arb2cc1 = ack_mem2arb &  r_owner;
        w_state_nxt = w_end ? S_IDLE : S_BURST;
      end
      S_BURST: begin
        // The cache keeps its address live during the refill, so follow it directly.
        adr_arb2mem = r_owner ? adr_cc12arb : adr_cc02arb;
        gnt_arb     = r_owner ? 2'b10 : 2'b01;
        ack_arb2cc0 = ack_mem2arb & ~r_owner;
        ack_arb2cc1 = ack_mem2arb &  r_owner;
        if (w_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend0    <= 1'b0;
      r_pend1    <= 1'b0;
      r_adr_lat0 <= '0;
      r_adr_lat1 <= '0;
      r_rr_ptr   <= 1'b0;
      r_owner    <= 1'b0;
      r_beat     <= '0;
    end else begin
      // The owner's pend stays set for the whole burst, so its requests are ignored too.
      if (req_cc02arb && !r_pend0) begin
        r_pend0    <= 1'b1;
        r_adr_lat0 <= adr_cc02arb;
      end else if (w_end && !r_owner) begin
        r_pend0 <= 1'b0;
      end
      if (req_cc12arb && !r_pend1) begin
        r_pend1    <= 1'b1;
        r_adr_lat1 <= adr_cc12arb;
      end else if (w_end && r_owner) begin
        r_pend1 <= 1'b0;
      end
      if (r_state == S_IDLE && (r_pend0 | r_pend1)) r_owner <= w_sel_owner;
      if (w_end) begin
        r_rr_ptr <= ~r_owner;
        r_beat   <= '0;
      end else if (w_beat_ack) begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant order, burst acks, stalls, async reset, watchdog.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int WW = 32;
  localparam int BL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] adr0 = '0, adr1 = '0;
  logic          ack0, ack1;
  logic [WW-1:0] dat_cc;
  logic          req_mem;
  logic [AW-1:0] adr_mem;
  logic          ack_mem = 1'b0;
  logic [WW-1:0] dat_mem = '0;
  logic [1:0]    gnt;
  logic          err;
  logic [4:0]    ctl;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.ADR_WIDTH(AW), .WORD_WIDTH(WW), .BURST_LEN(BL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_cc02arb(req0), .adr_cc02arb(adr0), .ack_arb2cc0(ack0),
    .req_cc12arb(req1), .adr_cc12arb(adr1), .ack_arb2cc1(ack1),
    .dat_arb2cc(dat_cc), .req_arb2mem(req_mem), .adr_arb2mem(adr_mem),
    .ack_mem2arb(ack_mem), .dat_mem2arb(dat_mem),
    .gnt_arb(gnt), .err_arb(err)
  );

  always #5 clk = ~clk;
  assign ctl = {req_mem, gnt, ack1, ack0};

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; ack_mem = 1'b0; dat_mem = '0;
    tick;
    tick;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; ack_mem = 1'b0; dat_mem = '0;
    #3;
    total++;
    if ({ctl, adr_mem, dat_cc, err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got ctl=%b adr=%h dat=%h err=%b exp all 0", ctl, adr_mem, dat_cc, err);
    end
    tick;
    rst = 1'b1;
    tick;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL reset_idle got=%b exp=%b", ctl, 5'b0_00_00); end
  endtask

  task automatic test_single_port0;
    do_reset;
    req0 = 1'b1; adr0 = 32'h0000_0100;
    tick;
    req0 = 1'b0;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL s0_pend_idle got=%b exp=%b", ctl, 5'b0_00_00); end
    tick;
    #1;
    total++;
    if (ctl !== 5'b1_01_00 || adr_mem !== 32'h100) begin
      bad++; $display("FAIL s0_issue got ctl=%b adr=%h exp ctl=10100 adr=100", ctl, adr_mem);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      ack_mem = 1'b1; dat_mem = 32'hD000 + i;
      if (i == 2) adr0 = 32'h0000_0108;
      #1;
      total++;
      if (ctl !== 5'b0_01_01 || adr_mem !== ((i >= 2) ? 32'h108 : 32'h100) || dat_cc !== 32'hD000 + i) begin
        bad++; $display("FAIL s0_beat%0d got ctl=%b adr=%h dat=%h", i, ctl, adr_mem, dat_cc);
      end
    end
    tick;
    ack_mem = 1'b0;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL s0_done got=%b exp=%b", ctl, 5'b0_00_00); end
    ack_mem = 1'b1;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL idle_ack_drop got=%b exp=%b", ctl, 5'b0_00_00); end
    tick;
    ack_mem = 1'b0;
    tick;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL idle_stays got=%b exp=%b", ctl, 5'b0_00_00); end
  endtask

  task automatic test_simultaneous;
    do_reset;
    req0 = 1'b1; req1 = 1'b1; adr0 = 32'h200; adr1 = 32'h300;
    tick;
    req0 = 1'b0; req1 = 1'b0; adr1 = 32'h999;
    tick;
    #1;
    total++;
    if (ctl !== 5'b1_01_00 || adr_mem !== 32'h200) begin
      bad++; $display("FAIL sim_issue0 got ctl=%b adr=%h exp ctl=10100 adr=200", ctl, adr_mem);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      ack_mem = 1'b1;
      #1;
      total++;
      if (ctl !== 5'b0_01_01) begin bad++; $display("FAIL sim_beat0_%0d got=%b exp=%b", i, ctl, 5'b0_01_01); end
    end
    tick;
    ack_mem = 1'b0;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL sim_gap got=%b exp=%b", ctl, 5'b0_00_00); end
    tick;
    #1;
    total++;
    if (ctl !== 5'b1_10_00 || adr_mem !== 32'h300) begin
      bad++; $display("FAIL sim_issue1 got ctl=%b adr=%h exp ctl=11000 adr=300", ctl, adr_mem);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      ack_mem = 1'b1;
      #1;
      total++;
      if (ctl !== 5'b0_10_10) begin bad++; $display("FAIL sim_beat1_%0d got=%b exp=%b", i, ctl, 5'b0_10_10); end
    end
    tick;
    ack_mem = 1'b0;
    req0 = 1'b1; req1 = 1'b1; adr0 = 32'h210; adr1 = 32'h310;
    tick;
    req0 = 1'b0; req1 = 1'b0;
    tick;
    #1;
    total++;
    if (ctl !== 5'b1_01_00 || adr_mem !== 32'h210) begin
      bad++; $display("FAIL rr_back_to_0 got ctl=%b adr=%h exp ctl=10100 adr=210", ctl, adr_mem);
    end
  endtask

  task automatic test_req_during_burst;
    do_reset;
    req0 = 1'b1; adr0 = 32'h100;
    tick;
    req0 = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      tick;
      req1 = 1'b0; ack_mem = 1'b1;
      if (i == 1) begin req1 = 1'b1; adr1 = 32'h0000_0A40; end
      if (i == 2) adr1 = 32'h0000_0FFF;
      if (i == 3) begin req1 = 1'b1; adr1 = 32'h0000_0BBB; end
      #1;
      total++;
      if (ctl !== 5'b0_01_01) begin bad++; $display("FAIL rdb_beat%0d got=%b exp=%b", i, ctl, 5'b0_01_01); end
    end
    tick;
    ack_mem = 1'b0; req1 = 1'b0;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL rdb_gap got=%b exp=%b", ctl, 5'b0_00_00); end
    tick;
    #1;
    total++;
    if (ctl !== 5'b1_10_00 || adr_mem !== 32'hA40) begin
      bad++; $display("FAIL rdb_issue1 got ctl=%b adr=%h exp ctl=11000 adr=a40", ctl, adr_mem);
    end
  endtask

  task automatic test_issue_ack;
    do_reset;
    req0 = 1'b1; adr0 = 32'h400;
    tick;
    req0 = 1'b0;
    tick;
    ack_mem = 1'b1;
    #1;
    total++;
    if (ctl !== 5'b1_01_01) begin bad++; $display("FAIL issue_ack got=%b exp=%b", ctl, 5'b1_01_01); end
    for (int i = 0; i < 3; i++) begin
      tick;
      #1;
      total++;
      if (ctl !== 5'b0_01_01) begin bad++; $display("FAIL issue_ack_beat%0d got=%b exp=%b", i, ctl, 5'b0_01_01); end
    end
    tick;
    ack_mem = 1'b0;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL issue_ack_done got=%b exp=%b", ctl, 5'b0_00_00); end
  endtask

  task automatic test_stall;
    do_reset;
    req1 = 1'b1; adr1 = 32'h500;
    tick;
    req1 = 1'b0;
    tick;
    #1;
    total++;
    if (ctl !== 5'b1_10_00 || adr_mem !== 32'h500) begin
      bad++; $display("FAIL stall_issue got ctl=%b adr=%h exp ctl=11000 adr=500", ctl, adr_mem);
    end
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 3; g++) begin
        tick;
        ack_mem = 1'b0;
        #1;
        total++;
        if (ctl !== 5'b0_10_00 || err !== 1'b0) begin
          bad++; $display("FAIL stall_gap%0d_%0d got ctl=%b err=%b exp ctl=01000 err=0", b, g, ctl, err);
        end
      end
      tick;
      ack_mem = 1'b1;
      #1;
      total++;
      if (ctl !== 5'b0_10_10) begin bad++; $display("FAIL stall_ack%0d got=%b exp=%b", b, ctl, 5'b0_10_10); end
    end
    tick;
    ack_mem = 1'b0;
    #1;
    total++;
    if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL stall_done got=%b exp=%b", ctl, 5'b0_00_00); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    req0 = 1'b1; req1 = 1'b1; adr0 = 32'h100; adr1 = 32'h300;
    tick;
    req0 = 1'b0; req1 = 1'b0;
    tick;
    tick;
    ack_mem = 1'b1;
    tick;
    dat_mem = '0;
    #1;
    rst = 1'b0;
    #1;
    total++;
    if ({ctl, adr_mem, dat_cc, err} !== '0) begin
      bad++; $display("FAIL midrst_outputs got ctl=%b adr=%h dat=%h err=%b exp all 0", ctl, adr_mem, dat_cc, err);
    end
    ack_mem = 1'b0;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      #1;
      total++;
      if (ctl !== 5'b0_00_00) begin bad++; $display("FAIL midrst_idle%0d got=%b exp=%b", i, ctl, 5'b0_00_00); end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    req0 = 1'b1; req1 = 1'b1; adr0 = 32'h100; adr1 = 32'h300;
    tick;
    req0 = 1'b0; req1 = 1'b0;
    tick;
    for (int i = 1; i <= 7; i++) begin
      tick;
      #1;
      total++;
      if (gnt !== 2'b01 || err !== 1'b0) begin
        bad++; $display("FAIL tmo_wait%0d got gnt=%b err=%b exp gnt=01 err=0", i, gnt, err);
      end
    end
    tick;
    #1;
    total++;
    if (gnt !== 2'b00 || err !== 1'b1) begin
      bad++; $display("FAIL tmo_pulse got gnt=%b err=%b exp gnt=00 err=1", gnt, err);
    end
    tick;
    #1;
    total++;
    if (ctl !== 5'b1_10_00 || err !== 1'b0 || adr_mem !== 32'h300) begin
      bad++; $display("FAIL tmo_next got ctl=%b err=%b adr=%h exp ctl=11000 err=0 adr=300", ctl, err, adr_mem);
    end
  endtask
`else
  task automatic test_no_timeout;
    do_reset;
    req0 = 1'b1; adr0 = 32'h100;
    tick;
    req0 = 1'b0;
    tick;
    for (int i = 0; i < 20; i++) begin
      tick;
      #1;
      total++;
      if (ctl !== 5'b0_01_00 || err !== 1'b0) begin
        bad++; $display("FAIL notmo_wait%0d got ctl=%b err=%b exp ctl=00100 err=0", i, ctl, err);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_port0;
    test_simultaneous;
    test_req_during_burst;
    test_issue_ack;
    test_stall;
    test_reset_mid_burst;
`ifdef ARB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
